vx_mem_watchdog: RTL and testbench
==================================

// Module: vx_mem_watchdog
// PURPOSE
//  Synthesizable run monitor on the Vortex mem_req/mem_rsp bus, between Vortex and Vortex_mem_slave.
//  Checks for four run outcomes:
//   - completion (busy falling edge)
//   - hang (no accepted request for HANG_CYCLES)
//   - timeout
//   - out-of-window addresses
//  Also tracks outstanding reads, emits a heartbeat pulse, and exposes counters/status for a CSR or bench.
// PARAMETERS
//  ADDR_W           26          mem_req_addr width (VX_MEM_ADDR_WIDTH)
//  CNT_W            32          cycle/request counter width
//  ADDR_MASK        26'h3C00000 address bits that are checked
//  ADDR_MATCH       26'h2000000 required value of (addr & ADDR_MASK); bits[25:22]=4'h8
//  HANG_CYCLES      1000        max cycles between accepted requests
//  TIMEOUT_CYCLES   1000000     max run length in cycles
//  HEARTBEAT_CYCLES 1000        heartbeat period in cycles
//  MAX_OUTSTANDING  64          outstanding-read capacity
// PORTS
//  clk            in  1          clock
//  nRST           in  1          async active-low reset
//  start          in  1          arm/re-arm pulse
//  busy           in  1          Vortex busy
//  mem_req_valid  in  1          request valid
//  mem_req_ready  in  1          request ready
//  mem_req_rw     in  1          1=write, 0=read
//  mem_req_addr   in  ADDR_W     request address
//  mem_rsp_valid  in  1          response valid
//  mem_rsp_ready  in  1          response ready
//  state          out 3          0 IDLE, 1 RUN, 2 DONE, 3 HANG, 4 TIMEOUT, 5 ADDR_ERR
//  heartbeat      out 1          1-cycle pulse every HEARTBEAT_CYCLES in RUN
//  rsp_err        out 1          sticky: rsp with none outstanding, or outstanding overflow
//  cycle_count    out CNT_W      cycles since entering RUN, saturating
//  req_count      out CNT_W      accepted requests, saturating
//  idle_cycles    out CNT_W      cycles since last accepted request
//  outstanding    out clog2(MAX_OUTSTANDING+1)  reads awaiting response
//  bad_addr       out ADDR_W     address of first out-of-window request
// BEHAVIOUR
//  - Definitions: req_fire = mem_req_valid & mem_req_ready; rsp_fire = mem_rsp_valid & mem_rsp_ready.
//  - Reset (nRST low, async): all outputs and registers are 0; state = IDLE; busy_q = 0.
//  - start=1 in any state: next cycle state = RUN, and all counters, rsp_err, bad_addr and the heartbeat counter are cleared.
//    - start has priority over every other transition that cycle.
//  - IDLE: counters hold at 0; bus activity is ignored.
//  - RUN, cycle_count: +1 per cycle.
//  - RUN, req_count: +1 on req_fire.
//  - RUN, idle_cycles: 0 on req_fire, else +1.
//  - RUN, outstanding (+1 on read req_fire, -1 on rsp_fire):
//    - read req_fire and rsp_fire in the same cycle: net 0.
//    - rsp_fire at 0: stays 0 and sets rsp_err.
//    - increment at MAX_OUTSTANDING: holds and sets rsp_err.
//  - RUN, heartbeat: down-counter reloads HEARTBEAT_CYCLES-1; pulse when it reaches 0.
//    - First pulse is in the HEARTBEAT_CYCLES-th RUN cycle.
//  - RUN exits, registered; priority when several hold in one cycle:
//    - ADDR_ERR: req_fire && (mem_req_addr & ADDR_MASK) != ADDR_MATCH; bad_addr captured that edge.
//    - HANG: idle_cycles == HANG_CYCLES-1 && !req_fire.
//    - TIMEOUT: cycle_count == TIMEOUT_CYCLES-1.
//    - DONE: busy_q & !busy (falling edge; busy low at entry is not done).
//  - Terminal states (DONE/HANG/TIMEOUT/ADDR_ERR) hold until start or reset.
//    - All counters, outstanding, bad_addr and rsp_err freeze; heartbeat = 0.
//  - Saturation: every CNT_W counter saturates at all-ones; no wrap.
//  - Reset mid-run: immediate IDLE; no partial results retained.
// TESTING
//  Bench params: HANG_CYCLES=8, TIMEOUT_CYCLES=50, HEARTBEAT_CYCLES=10, MAX_OUTSTANDING=2.
//  - Completion: start; req_fire (addr 26'h2000040) every 3 cycles; busy 1 then 0 at cycle 20
//    -> state=DONE, cycle_count=20, heartbeat pulsed at cycles 10 and 20.
//  - Hang: start; one req_fire at cycle 2, then none -> state=HANG after cycle 10, idle_cycles=8.
//  - Timeout: start; req_fire every 4 cycles, busy held 1 -> state=TIMEOUT, cycle_count=50.
//  - Bad address: req_fire addr 26'h1000000 at cycle 5, with busy falling the same cycle
//    -> ADDR_ERR wins, bad_addr=26'h1000000.
//  - Outstanding tracking:
//    - 3 back-to-back read fires, no rsp -> outstanding=2, rsp_err=1.
//    - After re-arm: rsp_fire with 0 outstanding -> rsp_err=1, state stays RUN.
//  - Reset and re-arm: nRST low mid-RUN -> all outputs 0 asynchronously.
//    - Subsequent start from HANG -> RUN with counters cleared.

Source files
------------

// File: rtl/vx_mem_watchdog.sv
// vx_mem_watchdog: run monitor sitting on the Vortex mem_req/mem_rsp bus.
// Classifies how a run ends (done, hang, timeout, out-of-window address),
// tracks outstanding reads and exposes run counters for a CSR block or bench.
module vx_mem_watchdog #(
  parameter int                ADDR_W           = 26,
  parameter int                CNT_W            = 32,
  parameter logic [ADDR_W-1:0] ADDR_MASK        = 26'h3C00000,
  parameter logic [ADDR_W-1:0] ADDR_MATCH       = 26'h2000000,
  parameter int                HANG_CYCLES      = 1000,
  parameter int                TIMEOUT_CYCLES   = 1000000,
  parameter int                HEARTBEAT_CYCLES = 1000,
  parameter int                MAX_OUTSTANDING  = 64
) (
  input  logic                                     clk,
  input  logic                                     nRST,
  input  logic                                     start,
  input  logic                                     busy,
  input  logic                                     mem_req_valid,
  input  logic                                     mem_req_ready,
  input  logic                                     mem_req_rw,
  input  logic [ADDR_W-1:0]                        mem_req_addr,
  input  logic                                     mem_rsp_valid,
  input  logic                                     mem_rsp_ready,
  output logic [2:0]                               state,
  output logic                                     heartbeat,
  output logic                                     rsp_err,
  output logic [CNT_W-1:0]                         cycle_count,
  output logic [CNT_W-1:0]                         req_count,
  output logic [CNT_W-1:0]                         idle_cycles,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding,
  output logic [ADDR_W-1:0]                        bad_addr
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RUN      = 3'd1;
  localparam logic [2:0] S_DONE     = 3'd2;
  localparam logic [2:0] S_HANG     = 3'd3;
  localparam logic [2:0] S_TIMEOUT  = 3'd4;
  localparam logic [2:0] S_ADDR_ERR = 3'd5;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] HANG_LAST   = CNT_W'(HANG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HB_RELOAD   = CNT_W'(HEARTBEAT_CYCLES - 1);
  localparam logic [OUT_W-1:0] OUT_MAX     = OUT_W'(MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0] OUT_ONE     = OUT_W'(1);

  logic             req_fire;
  logic             rsp_fire;
  logic             rd_fire;
  logic             addr_bad;
  logic             running;
  logic             busy_q;
  logic [CNT_W-1:0] hb_cnt;
  logic [2:0]       state_next;

  assign req_fire  = mem_req_valid & mem_req_ready;
  assign rsp_fire  = mem_rsp_valid & mem_rsp_ready;
  assign rd_fire   = req_fire & ~mem_req_rw;
  assign running   = (state == S_RUN);
  assign addr_bad  = req_fire && ((mem_req_addr & ADDR_MASK) != ADDR_MATCH);
  // The pulse is gated by RUN so terminal and idle states never beat.
  assign heartbeat = running && (hb_cnt == '0);

  // Next-state selection: start overrides everything, then exits in priority order
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = S_RUN;
    end else if (running) begin
      if (addr_bad) begin
        state_next = S_ADDR_ERR;
      end else if ((idle_cycles == HANG_LAST) && !req_fire) begin
        state_next = S_HANG;
      end else if (cycle_count == TMO_LAST) begin
        state_next = S_TIMEOUT;
      end else if (busy_q && !busy) begin
        state_next = S_DONE;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Delayed busy for falling-edge detection; sampled in every state
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= busy;
    end
  end

  // Saturating run counters; they only move while RUN, so terminal states freeze them
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      cycle_count <= '0;
      req_count   <= '0;
      idle_cycles <= '0;
    end else if (start) begin
      cycle_count <= '0;
      req_count   <= '0;
      idle_cycles <= '0;
    end else if (running) begin
      if (cycle_count != CNT_MAX) begin
        cycle_count <= cycle_count + CNT_ONE;
      end
      if (req_fire && (req_count != CNT_MAX)) begin
        req_count <= req_count + CNT_ONE;
      end
      if (req_fire) begin
        idle_cycles <= '0;
      end else if (idle_cycles != CNT_MAX) begin
        idle_cycles <= idle_cycles + CNT_ONE;
      end
    end
  end

  // Heartbeat down-counter: start loads a full period, reaching zero reloads it
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      hb_cnt <= '0;
    end else if (start) begin
      hb_cnt <= HB_RELOAD;
    end else if (running) begin
      if (hb_cnt == '0) begin
        hb_cnt <= HB_RELOAD;
      end else begin
        hb_cnt <= hb_cnt - CNT_ONE;
      end
    end
  end

  // Outstanding-read bookkeeping; underflow or overflow latches rsp_err instead of moving
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      outstanding <= '0;
      rsp_err     <= 1'b0;
    end else if (start) begin
      outstanding <= '0;
      rsp_err     <= 1'b0;
    end else if (running) begin
      if (rd_fire && !rsp_fire) begin
        if (outstanding == OUT_MAX) begin
          rsp_err <= 1'b1;
        end else begin
          outstanding <= outstanding + OUT_ONE;
        end
      end else if (rsp_fire && !rd_fire) begin
        if (outstanding == '0) begin
          rsp_err <= 1'b1;
        end else begin
          outstanding <= outstanding - OUT_ONE;
        end
      end
    end
  end

  // Capture the offending address; the run leaves RUN on that same edge so only the first is kept
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      bad_addr <= '0;
    end else if (start) begin
      bad_addr <= '0;
    end else if (running && addr_bad) begin
      bad_addr <= mem_req_addr;
    end
  end

endmodule

// File: tb/tb_vx_mem_watchdog.sv
// tb_vx_mem_watchdog: scenario tasks plus a randomized run, all checked
// against a timestamp-based behavioural model of the watchdog.
module tb_vx_mem_watchdog;

  localparam int HANG = 8;
  localparam int TMO  = 50;
  localparam int HB   = 10;
  localparam int MAXO = 2;

  localparam int ST_IDLE = 0;
  localparam int ST_RUN  = 1;
  localparam int ST_DONE = 2;
  localparam int ST_HANG = 3;
  localparam int ST_TMO  = 4;
  localparam int ST_ADDR = 5;

  logic        clk = 1'b0;
  logic        nRST;
  logic        start;
  logic        busy;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_rw;
  logic [25:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic        mem_rsp_ready;
  logic [2:0]  state;
  logic        heartbeat;
  logic        rsp_err;
  logic [31:0] cycle_count;
  logic [31:0] req_count;
  logic [31:0] idle_cycles;
  logic [1:0]  outstanding;
  logic [25:0] bad_addr;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: cycle index within the run and timestamp of the last accepted request
  int          m_state;
  int          m_cyc;
  int          m_reqs;
  int          m_last;
  int          m_out;
  bit          m_err;
  bit          m_busy_prev;
  logic [25:0] m_bad;
  int          act_hb;
  int          hb_bad;

  vx_mem_watchdog #(
    .HANG_CYCLES     (HANG),
    .TIMEOUT_CYCLES  (TMO),
    .HEARTBEAT_CYCLES(HB),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk          (clk),
    .nRST         (nRST),
    .start        (start),
    .busy         (busy),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_rw   (mem_req_rw),
    .mem_req_addr (mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_ready(mem_rsp_ready),
    .state        (state),
    .heartbeat    (heartbeat),
    .rsp_err      (rsp_err),
    .cycle_count  (cycle_count),
    .req_count    (req_count),
    .idle_cycles  (idle_cycles),
    .outstanding  (outstanding),
    .bad_addr     (bad_addr)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = ST_IDLE; m_cyc = 0; m_reqs = 0; m_last = 0; m_out = 0;
    m_err = 1'b0; m_busy_prev = 1'b0; m_bad = '0;
  endtask

  // One clock of the model, using the inputs currently on the bus
  task automatic model_step();
    bit rf, sf, rd, bad;
    int k, nxt;
    rf  = mem_req_valid && mem_req_ready;
    sf  = mem_rsp_valid && mem_rsp_ready;
    rd  = rf && !mem_req_rw;
    bad = rf && ((mem_req_addr < 26'h2000000) || (mem_req_addr >= 26'h2400000));
    if (start) begin
      m_state = ST_RUN; m_cyc = 0; m_reqs = 0; m_last = 0; m_out = 0;
      m_err = 1'b0; m_bad = '0;
    end else if (m_state == ST_RUN) begin
      k = m_cyc + 1;
      if (bad) nxt = ST_ADDR;
      else if (!rf && ((k - 1 - m_last) == HANG - 1)) nxt = ST_HANG;
      else if (k == TMO) nxt = ST_TMO;
      else if (m_busy_prev && !busy) nxt = ST_DONE;
      else nxt = ST_RUN;
      m_cyc = k;
      if (rf) begin
        m_reqs++;
        m_last = k;
      end
      if (rd && !sf) begin
        if (m_out == MAXO) m_err = 1'b1; else m_out++;
      end else if (sf && !rd) begin
        if (m_out == 0) m_err = 1'b1; else m_out--;
      end
      if (bad) m_bad = mem_req_addr;
      m_state = nxt;
    end
    m_busy_prev = busy;
  endtask

  // Advance one clock from a negedge to the next negedge, tallying heartbeat pulses
  task automatic step();
    bit exp_hb;
    #1;
    exp_hb = (m_state == ST_RUN) && (((m_cyc + 1) % HB) == 0);
    if (heartbeat !== exp_hb) hb_bad++;
    if (heartbeat === 1'b1) act_hb++;
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_bus();
    start = 1'b0; mem_req_valid = 1'b0; mem_req_ready = 1'b0; mem_req_rw = 1'b0;
    mem_req_addr = '0; mem_rsp_valid = 1'b0; mem_rsp_ready = 1'b0;
  endtask

  task automatic arm();
    idle_bus();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0; busy = 1'b0; idle_bus(); model_reset();
    repeat (3) @(negedge clk);
    vectors++; if (state !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
    vectors++; if (cycle_count !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_cycle_count: got %0d expected 0", cycle_count); end
    vectors++; if (req_count !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_req_count: got %0d expected 0", req_count); end
    vectors++; if (idle_cycles !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_idle_cycles: got %0d expected 0", idle_cycles); end
    vectors++; if (outstanding !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_outstanding: got %0d expected 0", outstanding); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rsp_err: got %0d expected 0", rsp_err); end
    vectors++; if (bad_addr !== 26'd0) begin miscompares++; $display("[TB] FAIL reset_bad_addr: got %h expected 0", bad_addr); end
    vectors++; if (heartbeat !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_heartbeat: got %0d expected 0", heartbeat); end
    nRST = 1'b1;
    // Bus traffic in IDLE, including a bad address, must be ignored
    for (int c = 0; c < 4; c++) begin
      mem_req_valid = 1'b1; mem_req_ready = 1'b1; mem_req_rw = 1'b0;
      mem_req_addr = 26'h1000000; mem_rsp_valid = 1'b1; mem_rsp_ready = 1'b1;
      busy = (c % 2 == 0);
      step();
    end
    idle_bus();
    vectors++; if (state !== 3'd0) begin miscompares++; $display("[TB] FAIL idle_state: got %0d expected 0", state); end
    vectors++; if (req_count !== 32'd0) begin miscompares++; $display("[TB] FAIL idle_req_count: got %0d expected 0", req_count); end
    vectors++; if (bad_addr !== 26'd0) begin miscompares++; $display("[TB] FAIL idle_bad_addr: got %h expected 0", bad_addr); end
  endtask

  task automatic test_completion();
    int hb0, bad0, cc;
    busy = 1'b1;
    arm();
    hb0 = act_hb; bad0 = hb_bad;
    for (int c = 1; c <= 20; c++) begin
      mem_req_valid = (c % 3 == 0); mem_req_ready = 1'b1;
      mem_req_rw = ($urandom_range(0, 1) == 1); mem_req_addr = 26'h2000040;
      mem_rsp_valid = ($urandom_range(0, 2) == 0); mem_rsp_ready = 1'b1;
      busy = (c < 20);
      step();
    end
    idle_bus();
    vectors++; if (state !== 3'd2) begin miscompares++; $display("[TB] FAIL done_state: got %0d expected 2", state); end
    vectors++; if (cycle_count !== 32'd20) begin miscompares++; $display("[TB] FAIL done_cycle_count: got %0d expected 20", cycle_count); end
    vectors++; if (req_count !== 32'd6) begin miscompares++; $display("[TB] FAIL done_req_count: got %0d expected 6", req_count); end
    vectors++; if ((act_hb - hb0) != 2) begin miscompares++; $display("[TB] FAIL done_hb_pulses: got %0d expected 2", act_hb - hb0); end
    vectors++; if (hb_bad != bad0) begin miscompares++; $display("[TB] FAIL done_hb_timing: got %0d misplaced expected 0", hb_bad - bad0); end
    vectors++; if (outstanding !== 2'(m_out)) begin miscompares++; $display("[TB] FAIL done_outstanding: got %0d expected %0d", outstanding, m_out); end
    vectors++; if (rsp_err !== m_err) begin miscompares++; $display("[TB] FAIL done_rsp_err: got %0d expected %0d", rsp_err, m_err); end
    // Terminal state must freeze under continued traffic
    hb0 = act_hb; cc = m_cyc;
    for (int c = 0; c < 3; c++) begin
      mem_req_valid = 1'b1; mem_req_ready = 1'b1; mem_req_rw = 1'b0;
      mem_req_addr = 26'h0000100; mem_rsp_valid = 1'b1; mem_rsp_ready = 1'b1;
      busy = (c == 1);
      step();
    end
    idle_bus();
    vectors++; if (state !== 3'd2) begin miscompares++; $display("[TB] FAIL freeze_state: got %0d expected 2", state); end
    vectors++; if (cycle_count !== 32'(cc)) begin miscompares++; $display("[TB] FAIL freeze_cycle_count: got %0d expected %0d", cycle_count, cc); end
    vectors++; if (bad_addr !== 26'd0) begin miscompares++; $display("[TB] FAIL freeze_bad_addr: got %h expected 0", bad_addr); end
    vectors++; if (act_hb != hb0) begin miscompares++; $display("[TB] FAIL freeze_heartbeat: got %0d pulses expected 0", act_hb - hb0); end
  endtask

  task automatic test_hang();
    int n;
    busy = 1'b1;
    arm();
    n = 0;
    for (int c = 1; c <= 30; c++) begin
      mem_req_valid = (c == 2); mem_req_ready = 1'b1; mem_req_rw = 1'b1;
      mem_req_addr = 26'h2000080;
      step();
      n = c;
      if (state !== 3'd1) break;
    end
    idle_bus();
    vectors++; if (state !== 3'd3) begin miscompares++; $display("[TB] FAIL hang_state: got %0d expected 3", state); end
    vectors++; if (n != 10) begin miscompares++; $display("[TB] FAIL hang_cycle: got %0d expected 10", n); end
    vectors++; if (idle_cycles !== 32'd8) begin miscompares++; $display("[TB] FAIL hang_idle_cycles: got %0d expected 8", idle_cycles); end
    vectors++; if (req_count !== 32'd1) begin miscompares++; $display("[TB] FAIL hang_req_count: got %0d expected 1", req_count); end
  endtask

  task automatic test_timeout();
    int n, hb0;
    busy = 1'b1;
    arm();
    hb0 = act_hb; n = 0;
    for (int c = 1; c <= 80; c++) begin
      mem_req_valid = (c % 4 == 0); mem_req_ready = 1'b1;
      mem_req_rw = ($urandom_range(0, 1) == 1);
      mem_req_addr = {4'h8, 22'($urandom)};
      mem_rsp_valid = ($urandom_range(0, 3) == 0); mem_rsp_ready = 1'b1;
      step();
      n = c;
      if (state !== 3'd1) break;
    end
    idle_bus();
    vectors++; if (state !== 3'd4) begin miscompares++; $display("[TB] FAIL tmo_state: got %0d expected 4", state); end
    vectors++; if (n != 50) begin miscompares++; $display("[TB] FAIL tmo_cycle: got %0d expected 50", n); end
    vectors++; if (cycle_count !== 32'd50) begin miscompares++; $display("[TB] FAIL tmo_cycle_count: got %0d expected 50", cycle_count); end
    vectors++; if (req_count !== 32'd12) begin miscompares++; $display("[TB] FAIL tmo_req_count: got %0d expected 12", req_count); end
    vectors++; if ((act_hb - hb0) != 5) begin miscompares++; $display("[TB] FAIL tmo_hb_pulses: got %0d expected 5", act_hb - hb0); end
    vectors++; if (outstanding !== 2'(m_out)) begin miscompares++; $display("[TB] FAIL tmo_outstanding: got %0d expected %0d", outstanding, m_out); end
  endtask

  task automatic test_bad_addr();
    busy = 1'b1;
    arm();
    for (int c = 1; c <= 5; c++) begin
      mem_req_valid = (c == 5); mem_req_ready = 1'b1; mem_req_rw = 1'b1;
      mem_req_addr = 26'h1000000;
      busy = (c < 5);
      step();
    end
    idle_bus();
    step();
    vectors++; if (state !== 3'd5) begin miscompares++; $display("[TB] FAIL addr_state: got %0d expected 5", state); end
    vectors++; if (bad_addr !== 26'h1000000) begin miscompares++; $display("[TB] FAIL addr_bad_addr: got %h expected 1000000", bad_addr); end
    vectors++; if (cycle_count !== 32'd5) begin miscompares++; $display("[TB] FAIL addr_cycle_count: got %0d expected 5", cycle_count); end
    vectors++; if (req_count !== 32'd1) begin miscompares++; $display("[TB] FAIL addr_req_count: got %0d expected 1", req_count); end
  endtask

  task automatic test_outstanding();
    busy = 1'b1;
    arm();
    for (int c = 1; c <= 3; c++) begin
      mem_req_valid = 1'b1; mem_req_ready = 1'b1; mem_req_rw = 1'b0;
      mem_req_addr = 26'h2000000 + 26'(c * 64);
      step();
    end
    idle_bus();
    vectors++; if (outstanding !== 2'd2) begin miscompares++; $display("[TB] FAIL ovf_outstanding: got %0d expected 2", outstanding); end
    vectors++; if (rsp_err !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_rsp_err: got %0d expected 1", rsp_err); end
    vectors++; if (state !== 3'd1) begin miscompares++; $display("[TB] FAIL ovf_state: got %0d expected 1", state); end
    arm();
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("[TB] FAIL rearm_rsp_err: got %0d expected 0", rsp_err); end
    vectors++; if (outstanding !== 2'd0) begin miscompares++; $display("[TB] FAIL rearm_outstanding: got %0d expected 0", outstanding); end
    mem_rsp_valid = 1'b1; mem_rsp_ready = 1'b1;
    step();
    idle_bus();
    vectors++; if (rsp_err !== 1'b1) begin miscompares++; $display("[TB] FAIL unf_rsp_err: got %0d expected 1", rsp_err); end
    vectors++; if (outstanding !== 2'd0) begin miscompares++; $display("[TB] FAIL unf_outstanding: got %0d expected 0", outstanding); end
    vectors++; if (state !== 3'd1) begin miscompares++; $display("[TB] FAIL unf_state: got %0d expected 1", state); end
    // One read, then a read and a response together: net zero keeps the count at 1
    mem_req_valid = 1'b1; mem_req_ready = 1'b1; mem_req_rw = 1'b0; mem_req_addr = 26'h2000400;
    step();
    mem_rsp_valid = 1'b1; mem_rsp_ready = 1'b1;
    step();
    idle_bus();
    vectors++; if (outstanding !== 2'd1) begin miscompares++; $display("[TB] FAIL net0_outstanding: got %0d expected 1", outstanding); end
  endtask

  task automatic test_reset_rearm();
    int n;
    busy = 1'b1;
    arm();
    for (int c = 1; c <= 5; c++) begin
      mem_req_valid = (c >= 2); mem_req_ready = 1'b1; mem_req_rw = 1'b0;
      mem_req_addr = 26'h2000100;
      mem_rsp_valid = (c == 1); mem_rsp_ready = 1'b1;
      step();
    end
    idle_bus();
    #2 nRST = 1'b0;
    #1;
    model_reset();
    vectors++; if (state !== 3'd0) begin miscompares++; $display("[TB] FAIL async_state: got %0d expected 0", state); end
    vectors++; if (cycle_count !== 32'd0) begin miscompares++; $display("[TB] FAIL async_cycle_count: got %0d expected 0", cycle_count); end
    vectors++; if (req_count !== 32'd0) begin miscompares++; $display("[TB] FAIL async_req_count: got %0d expected 0", req_count); end
    vectors++; if (outstanding !== 2'd0) begin miscompares++; $display("[TB] FAIL async_outstanding: got %0d expected 0", outstanding); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("[TB] FAIL async_rsp_err: got %0d expected 0", rsp_err); end
    @(negedge clk);
    nRST = 1'b1;
    busy = 1'b1;
    arm();
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      n = c;
      if (state !== 3'd1) break;
    end
    vectors++; if (state !== 3'd3) begin miscompares++; $display("[TB] FAIL rearm_hang_state: got %0d expected 3", state); end
    vectors++; if (n != 8) begin miscompares++; $display("[TB] FAIL rearm_hang_cycle: got %0d expected 8", n); end
    arm();
    vectors++; if (state !== 3'd1) begin miscompares++; $display("[TB] FAIL from_hang_state: got %0d expected 1", state); end
    vectors++; if (cycle_count !== 32'd0) begin miscompares++; $display("[TB] FAIL from_hang_cycle_count: got %0d expected 0", cycle_count); end
    vectors++; if (idle_cycles !== 32'd0) begin miscompares++; $display("[TB] FAIL from_hang_idle_cycles: got %0d expected 0", idle_cycles); end
  endtask

  task automatic test_random();
    int bad0;
    bad0 = hb_bad;
    for (int run = 0; run < 6; run++) begin
      busy = 1'b1;
      arm();
      for (int c = 0; c < 60; c++) begin
        start = ($urandom_range(0, 49) == 0);
        busy = ($urandom_range(0, 9) != 0);
        mem_req_valid = ($urandom_range(0, 1) == 1);
        mem_req_ready = ($urandom_range(0, 3) != 0);
        mem_req_rw = ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 19) == 0) mem_req_addr = 26'($urandom);
        else mem_req_addr = {4'h8, 22'($urandom)};
        mem_rsp_valid = ($urandom_range(0, 2) == 0);
        mem_rsp_ready = ($urandom_range(0, 3) != 0);
        step();
        vectors++; if (state !== 3'(m_state)) begin miscompares++; $display("[TB] FAIL rnd_state run %0d cyc %0d: got %0d expected %0d", run, c, state, m_state); end
        vectors++; if (cycle_count !== 32'(m_cyc)) begin miscompares++; $display("[TB] FAIL rnd_cycle_count run %0d cyc %0d: got %0d expected %0d", run, c, cycle_count, m_cyc); end
        vectors++; if (req_count !== 32'(m_reqs)) begin miscompares++; $display("[TB] FAIL rnd_req_count run %0d cyc %0d: got %0d expected %0d", run, c, req_count, m_reqs); end
        vectors++; if (idle_cycles !== 32'(m_cyc - m_last)) begin miscompares++; $display("[TB] FAIL rnd_idle_cycles run %0d cyc %0d: got %0d expected %0d", run, c, idle_cycles, m_cyc - m_last); end
        vectors++; if (outstanding !== 2'(m_out)) begin miscompares++; $display("[TB] FAIL rnd_outstanding run %0d cyc %0d: got %0d expected %0d", run, c, outstanding, m_out); end
        vectors++; if (rsp_err !== m_err) begin miscompares++; $display("[TB] FAIL rnd_rsp_err run %0d cyc %0d: got %0d expected %0d", run, c, rsp_err, m_err); end
        vectors++; if (bad_addr !== m_bad) begin miscompares++; $display("[TB] FAIL rnd_bad_addr run %0d cyc %0d: got %h expected %h", run, c, bad_addr, m_bad); end
      end
      idle_bus();
    end
    vectors++; if (hb_bad != bad0) begin miscompares++; $display("[TB] FAIL rnd_heartbeat: got %0d misplaced pulses expected 0", hb_bad - bad0); end
  endtask

  initial begin
    act_hb = 0; hb_bad = 0;
    test_reset();
    test_completion();
    test_hang();
    test_timeout();
    test_bad_addr();
    test_outstanding();
    test_reset_rearm();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_time_limit: got no completion expected finish");
    $fatal(1, "[TB] time limit expired");
  end

endmodule
